// File: rtl/mem_d1_stream_reader.sv
// mem_d1_stream_reader
//
// Sequencer in front of a combinational-read 1-D memory (std_mem_d1 port shape).
// A go pulse in idle captures base/count; the block then walks `count` consecutive
// addresses from `base`, wrapping at SIZE, and presents each word as a valid/ready
// stream beat from a single registered output slot. done pulses for one cycle once
// the final beat has been accepted (or straight after start when count == 0).
//
// Optional feature: define MEM_D1_STREAM_READER_LAST_EN to add out_last, which marks
// the final beat of a transfer.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   go, base, count  start request and transfer description (sampled in idle only)
//   mem_addr0        memory address (always the internal address register)
//   mem_write_en     memory write enable, tied low (read-only use)
//   mem_write_data   memory write data, tied to zero
//   mem_read_data    memory read data, combinational from mem_addr0
//   out_data         stream payload
//   out_valid        stream valid
//   out_ready        stream ready from consumer
//   out_last         final-beat marker (only with MEM_D1_STREAM_READER_LAST_EN)
//   busy             high while a transfer is in progress (run or done)
//   done             one-cycle completion pulse
module mem_d1_stream_reader #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [IDX_SIZE:0]   count,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic                mem_write_en,
  output logic [WIDTH-1:0]    mem_write_data,
  input  logic [WIDTH-1:0]    mem_read_data,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
`ifdef MEM_D1_STREAM_READER_LAST_EN
  ,
  output logic                out_last
`endif
);

  localparam logic [IDX_SIZE:0]   SizeExt  = (IDX_SIZE + 1)'(SIZE);
  localparam logic [IDX_SIZE-1:0] AddrLast = IDX_SIZE'(SIZE - 1);
  localparam logic [IDX_SIZE:0]   RemOne   = (IDX_SIZE + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_SIZE-1:0] addr_q, addr_d;
  logic [IDX_SIZE:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
`ifdef MEM_D1_STREAM_READER_LAST_EN
  logic                last_q, last_d;
`endif
  logic                slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
`ifdef MEM_D1_STREAM_READER_LAST_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
`ifdef MEM_D1_STREAM_READER_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

  // The slot can take a new word when empty or when its current beat leaves this cycle.
  assign slot_free = !valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
`ifdef MEM_D1_STREAM_READER_LAST_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (go) begin
          remaining_d = count;
          // Out-of-range start addresses fall back to word 0.
          addr_d      = ({1'b0, base} >= SizeExt) ? '0 : base;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (remaining_q != '0) begin
          // Under backpressure everything holds and the memory is not re-read.
          if (slot_free) begin
            data_d      = mem_read_data;
            valid_d     = 1'b1;
`ifdef MEM_D1_STREAM_READER_LAST_EN
            last_d      = (remaining_q == RemOne);
`endif
            addr_d      = (addr_q == AddrLast) ? '0 : addr_q + IDX_SIZE'(1);
            remaining_d = remaining_q - RemOne;
          end
        end else begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
          end
          if (slot_free) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_addr0      = addr_q;
  assign mem_write_en   = 1'b0;
  assign mem_write_data = '0;
  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
`ifdef MEM_D1_STREAM_READER_LAST_EN
  assign out_last       = last_q;
`endif

endmodule

// File: tb/tb_mem_d1_stream_reader.sv
// Bench for mem_d1_stream_reader: a behavioural memory plus a reference model that
// predicts the beat sequence as mem[(base + i) % SIZE] for i < count and the cycle
// on which done must pulse, under ready held high, a fixed toggle pattern, or random
// backpressure. Also covers reset mid-stream and go while busy.
module tb_mem_d1_stream_reader;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned SIZE     = 16;
  localparam int unsigned IDX_SIZE = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                go;
  logic [IDX_SIZE-1:0] base;
  logic [IDX_SIZE:0]   count;
  logic [IDX_SIZE-1:0] mem_addr0;
  logic                mem_write_en;
  logic [WIDTH-1:0]    mem_write_data;
  logic [WIDTH-1:0]    mem_read_data;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;
`ifdef MEM_D1_STREAM_READER_LAST_EN
  logic                out_last;
`endif

  logic [WIDTH-1:0] mem [SIZE];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr0];

  mem_d1_stream_reader #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .IDX_SIZE (IDX_SIZE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .go             (go),
    .base           (base),
    .count          (count),
    .mem_addr0      (mem_addr0),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
`ifdef MEM_D1_STREAM_READER_LAST_EN
    ,
    .out_last       (out_last)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mode 0: ready always high; 1: repeating 1,0,0,1,1; 2: random ready.
  task automatic run_xfer(input int b, input int n, input int mode);
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] pd;
    bit               pv, pr, finished, exp_done;
    int               last_acc;
    bit               pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % SIZE]);
    @(negedge clk);
    go        = 1'b1;
    base      = IDX_SIZE'(b);
    count     = (IDX_SIZE + 1)'(n);
    out_ready = 1'b1;
    check_eq("idle_busy", {63'd0, busy}, 64'd0);
    last_acc = -10;
    pv = 1'b0; pr = 1'b0; pd = '0; finished = 1'b0;
    for (int c = 1; c <= 400 && !finished; c++) begin
      @(negedge clk);
      // Stray go requests with junk parameters must be ignored while busy.
      go    = ($urandom_range(0, 3) == 0);
      base  = IDX_SIZE'($urandom);
      count = (IDX_SIZE + 1)'($urandom);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[c % 5];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check_eq("wr_en", {63'd0, mem_write_en}, 64'd0);
      check_eq("busy", {63'd0, busy}, 64'd1);
      if (c <= 2) check_eq("first_valid", {63'd0, out_valid}, {63'd0, (c == 2 && n != 0)});
      if (pv && !pr) begin
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_data", 64'(out_data), 64'(pd));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", {63'd0, out_valid}, 64'd0);
        end else begin
          check_eq("beat", 64'(out_data), 64'(exp_q.pop_front()));
`ifdef MEM_D1_STREAM_READER_LAST_EN
          check_eq("last", {63'd0, out_last}, {63'd0, exp_q.size() == 0});
`endif
          last_acc = c;
        end
      end
      exp_done = (n == 0) ? (c == 2) : (exp_q.size() == 0 && c == last_acc + 1);
      check_eq("done", {63'd0, done}, {63'd0, exp_done});
      if (done) begin
        finished = 1'b1;
        if (mode == 0) check_eq("done_cycle", 64'(c), 64'(n + 2));
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end
    if (!finished) check_eq("timeout", {63'd0, finished}, 64'd1);
    check_eq("leftover", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    go = 1'b0;
    check_eq("post_busy", {63'd0, busy}, 64'd0);
    check_eq("post_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic reset_mid_stream(input int b);
    @(negedge clk);
    go = 1'b1; base = IDX_SIZE'(b); count = (IDX_SIZE + 1)'(8); out_ready = 1'b1;
    @(negedge clk);  // cycle 1
    go = 1'b0;
    @(negedge clk);  // cycle 2: go with another base must be ignored
    go = 1'b1; base = IDX_SIZE'(b + 7);
    check_eq("rst_beat0", 64'(out_data), 64'(mem[b % SIZE]));
    @(negedge clk);  // cycle 3
    go = 1'b0;
    check_eq("rst_beat1", 64'(out_data), 64'(mem[(b + 1) % SIZE]));
    @(negedge clk);  // cycle 4
    reset = 1'b1;
    @(negedge clk);  // cycle 5
    reset = 1'b0;
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_addr", 64'(mem_addr0), 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    check_eq("rst_stay_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; base = '0; count = '0; out_ready = 1'b1;
    for (int i = 0; i < int'(SIZE); i++) mem[i] = WIDTH'(i * 16 + 3);
    repeat (2) @(negedge clk);
    check_eq("reset_valid", {63'd0, out_valid}, 64'd0);
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_done", {63'd0, done}, 64'd0);
    check_eq("reset_addr", 64'(mem_addr0), 64'd0);
    check_eq("reset_data", 64'(out_data), 64'd0);
    reset = 1'b0;

    run_xfer(2, 4, 0);
    run_xfer(14, 4, 0);
    run_xfer(0, 3, 1);
    run_xfer(5, 0, 0);
    run_xfer(7, 1, 0);
    run_xfer(9, 20, 0);
    reset_mid_stream(3);
    run_xfer(1, 3, 0);

    for (int i = 0; i < int'(SIZE); i++) mem[i] = $urandom;
    for (int t = 0; t < 30; t++) begin
      run_xfer(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
